// File: rtl/miner_pkg.sv
// Shared definitions for the miner datapath: nonce width, pipe latency and
// the default golden-hash compare target.
package miner_pkg;

    localparam int NONCE_W = 32;

    // Latency of the SHA-256 pipe from nonce issue to hash output.
    localparam int SHA_PIPE_LATENCY = 8;

    // 0 - H7 initial value: word 7 before the final add equals this when
    // H7 is zero after the final add.
    localparam logic [31:0] MATCH_VALUE_DEFAULT = 32'ha41f32e7;
    localparam logic [31:0] MATCH_MASK_DEFAULT  = 32'hffffffff;

    // One tag travelling alongside the hash pipe.
    typedef struct packed {
        logic               valid;
        logic [NONCE_W-1:0] nonce;
    } tag_t;

    // Masked equality of hash word 7 against the target; mask 0 = don't care.
    function automatic logic word7_match(input logic [31:0] w7,
                                         input logic [31:0] value,
                                         input logic [31:0] mask);
        return ((w7 ^ value) & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/gn_fifo.sv
// Small synchronous first-word-fall-through FIFO. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module gn_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    count_q,  count_d;
    logic             pop_ok, push_ok;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == LW'(DEPTH));
    assign level_o    = count_q;
    // Head entry falls through; an empty FIFO presents zero.
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Next pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/golden_nonce_checker.sv
// Tracks nonces through the hash pipe, flags hashes whose word 7 hits the
// target and queues the matching nonces for the reporting side.
module golden_nonce_checker
    import miner_pkg::*;
#(
    parameter int          LATENCY     = SHA_PIPE_LATENCY,
    parameter logic [31:0] MATCH_VALUE = MATCH_VALUE_DEFAULT,
    parameter logic [31:0] MATCH_MASK  = MATCH_MASK_DEFAULT,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        nonce_valid,
    input  logic [NONCE_W-1:0]          nonce,
    input  logic                        flush,
    input  logic [255:0]                hash,
    output logic                        gn_valid,
    output logic [NONCE_W-1:0]          gn_nonce,
    input  logic                        gn_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_count,
    output logic                        overflow,
    input  logic                        clear_ovf
);

    // Handshake: gn_nonce is offered while gn_valid is high and is consumed
    // on any rising edge where gn_valid & gn_ready; it holds otherwise.

    logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [NONCE_W-1:0] tag_nonce_q [LATENCY];
    tag_t               tag_out;
    logic               match_q, match_d;
    logic [NONCE_W-1:0] match_nonce_q;
    logic               fifo_full, fifo_empty, drop;
    logic [15:0]        drop_count_q, drop_count_d;
    logic               overflow_q, overflow_d;
    logic               unused_hash_bits;

    assign unused_hash_bits = ^hash[223:0];
    assign tag_out = '{valid: tag_valid_q[LATENCY-1], nonce: tag_nonce_q[LATENCY-1]};

    // Valid bits shift one stage per cycle; flush kills everything in flight
    // including a nonce issued in the flush cycle.
    always_comb begin
        tag_valid_d    = '0;
        tag_valid_d[0] = nonce_valid;
        for (int i = 1; i < LATENCY; i++) tag_valid_d[i] = tag_valid_q[i-1];
        if (flush) tag_valid_d = '0;
    end

    // Valid-bit shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_valid_q <= '0;
        else        tag_valid_q <= tag_valid_d;
    end

    // Nonce shift register; qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        tag_nonce_q[0] <= nonce;
        for (int i = 1; i < LATENCY; i++) tag_nonce_q[i] <= tag_nonce_q[i-1];
    end

    // Compare the aligned tag's hash word 7; a flush also drops the result.
    always_comb begin
        match_d = tag_out.valid & word7_match(hash[255:224], MATCH_VALUE, MATCH_MASK) & ~flush;
    end

    // Registered match flag feeding the FIFO push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) match_q <= 1'b0;
        else        match_q <= match_d;
    end

    // Registered nonce accompanying the match flag.
    always_ff @(posedge clk) begin
        match_nonce_q <= tag_out.nonce;
    end

    gn_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (match_q),
        .push_data_i (match_nonce_q),
        .pop_i       (gn_ready),
        .pop_data_o  (gn_nonce),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    assign gn_valid = ~fifo_empty;
    assign drop     = match_q & fifo_full & ~(gn_valid & gn_ready);

    // Drop accounting; a drop in the clear cycle still gets counted.
    always_comb begin
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (clear_ovf) begin
            drop_count_d = 16'h0;
            overflow_d   = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_ovf)                   drop_count_d = 16'h1;
            else if (drop_count_q != 16'hffff) drop_count_d = drop_count_q + 16'h1;
        end
    end

    // Drop counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= 16'h0;
            overflow_q   <= 1'b0;
        end else begin
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_golden_nonce_checker.sv
// Directed bench for golden_nonce_checker (LATENCY 8, mask ffff0000, depth 4).
module tb_golden_nonce_checker;

    localparam logic [31:0] HIT  = 32'ha41f32e7;
    localparam logic [31:0] MISS = 32'ha41e32e7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         nonce_valid = 1'b0;
    logic [31:0]  nonce = '0;
    logic         flush = 1'b0;
    logic [255:0] hash = '0;
    logic         gn_valid;
    logic [31:0]  gn_nonce;
    logic         gn_ready = 1'b0;
    logic [2:0]   fifo_level;
    logic [15:0]  drop_count;
    logic         overflow;
    logic         clear_ovf = 1'b0;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_pops = 0;
    int pops_before;
    logic [31:0] exp_q[$];

    golden_nonce_checker #(
        .LATENCY    (8),
        .MATCH_MASK (32'hffff0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nonce_valid (nonce_valid),
        .nonce       (nonce),
        .flush       (flush),
        .hash        (hash),
        .gn_valid    (gn_valid),
        .gn_nonce    (gn_nonce),
        .gn_ready    (gn_ready),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then move to 1 time unit after the next edge.
    task automatic run_cycle(input logic nv, input logic [31:0] n, input logic [31:0] w7,
                             input logic fl, input logic rdy, input logic clr);
        nonce_valid = nv;
        nonce       = n;
        hash        = {w7, 192'd0, 32'($urandom)};
        flush       = fl;
        gn_ready    = rdy;
        clear_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted golden nonce must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && gn_valid && gn_ready) begin
            n_pops++;
            if (exp_q.size() == 0) check("pop_unexpected", 32'(exp_q.size()), 32'd1);
            else                   check("pop_nonce", gn_nonce, exp_q.pop_front());
        end
    end

    initial begin
        // reset state
        #12;
        check("rst_gn_valid", 32'(gn_valid), 32'd0);
        check("rst_gn_nonce", gn_nonce, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single golden nonce, latency check
        exp_q.push_back(32'h10);
        for (int c = 0; c <= 12; c++) begin
            run_cycle(c == 0, 32'h10, (c == 8) ? HIT : MISS, 1'b0, c >= 12, 1'b0);
            if (c == 8) check("t1_not_yet", 32'(gn_valid), 32'd0);
            if (c == 9) begin
                check("t1_valid", 32'(gn_valid), 32'd1);
                check("t1_nonce", gn_nonce, 32'h10);
                check("t1_level", 32'(fifo_level), 32'd1);
            end
            if (c == 11) check("t1_hold", gn_nonce, 32'h10);
        end
        check("t1_level_after_pop", 32'(fifo_level), 32'd0);
        check("t1_valid_after_pop", 32'(gn_valid), 32'd0);

        // stream of nonces, masked compare, only nonce 42 matches
        pops_before = n_pops;
        exp_q.push_back(32'h2a);
        for (int c = 0; c <= 111; c++)
            run_cycle(c < 100, 32'(c), (c == 50) ? 32'ha41f0000 : MISS, 1'b0, 1'b1, 1'b0);
        check("t2_pops", 32'(n_pops - pops_before), 32'd1);
        check("t2_exp_left", 32'(exp_q.size()), 32'd0);

        // flush: nonce 5 killed, nonce 7 (with flush) killed, nonce 6 kept;
        // nonce 8's compare result is killed by a flush in its compare cycle
        pops_before = n_pops;
        exp_q.push_back(32'd6);
        for (int c = 0; c <= 18; c++)
            run_cycle(c == 0 || c == 3 || c == 4 || c == 5,
                      (c == 0) ? 32'd5 : (c == 3) ? 32'd7 : (c == 4) ? 32'd6 : 32'd8,
                      (c == 8 || c == 11 || c == 12 || c == 13) ? HIT : MISS,
                      c == 3 || c == 13, 1'b1, 1'b0);
        check("t3_pops", 32'(n_pops - pops_before), 32'd1);
        check("t3_level", 32'(fifo_level), 32'd0);

        // six matches into a depth-4 FIFO with no consumer
        for (int c = 0; c <= 16; c++)
            run_cycle(c < 6, 32'(100 + c), (c >= 8 && c <= 13) ? HIT : MISS, 1'b0, 1'b0, 1'b0);
        check("t4_level", 32'(fifo_level), 32'd4);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_drop", 32'(drop_count), 32'd2);
        check("t4_head", gn_nonce, 32'd100);

        // full FIFO: push and pop in the same cycle
        exp_q.push_back(32'd100);
        for (int c = 0; c <= 12; c++)
            run_cycle(c == 0, 32'd106, (c == 8) ? HIT : MISS, 1'b0, c == 9, 1'b0);
        check("t5_level", 32'(fifo_level), 32'd4);
        check("t5_drop", 32'(drop_count), 32'd2);
        check("t5_head", gn_nonce, 32'd101);

        // clear_ovf coincident with a drop
        for (int c = 0; c <= 12; c++)
            run_cycle(c == 0, 32'd107, (c == 8) ? HIT : MISS, 1'b0, 1'b0, c == 9);
        check("t5_clr_drop", 32'(drop_count), 32'd1);
        check("t5_clr_ovf", 32'(overflow), 32'd1);
        check("t5_clr_level", 32'(fifo_level), 32'd4);

        // drain in order, new nonce at the tail
        exp_q.push_back(32'd101);
        exp_q.push_back(32'd102);
        exp_q.push_back(32'd103);
        exp_q.push_back(32'd106);
        for (int c = 0; c <= 5; c++)
            run_cycle(1'b0, 32'd0, MISS, 1'b0, 1'b1, 1'b0);
        check("drain_exp_left", 32'(exp_q.size()), 32'd0);
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_valid", 32'(gn_valid), 32'd0);

        // reset mid-stream with 3 queued and nonce 210 in flight
        for (int c = 0; c <= 12; c++)
            run_cycle(c < 3 || c == 9, (c == 9) ? 32'd210 : 32'(200 + c),
                      (c >= 8 && c <= 10) ? HIT : MISS, 1'b0, 1'b0, 1'b0);
        check("t6_pre_level", 32'(fifo_level), 32'd3);
        check("t6_pre_drop", 32'(drop_count), 32'd1);
        nonce_valid = 1'b0;
        hash        = {MISS, 224'd0};
        rst_n       = 1'b0;
        #1;
        check("t6_rst_valid", 32'(gn_valid), 32'd0);
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        check("t6_rst_drop", 32'(drop_count), 32'd0);
        check("t6_rst_nonce", gn_nonce, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pops_before = n_pops;
        for (int c = 15; c <= 22; c++)
            run_cycle(1'b0, 32'd0, (c == 17) ? HIT : MISS, 1'b0, 1'b1, 1'b0);
        check("t6_pops", 32'(n_pops - pops_before), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
